alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, sequential successor to the single-cycle datapath ALU of the multi-cycle RISC-V core.
- Adds RV32M/RV64M-style REM/REMU and a fully RISC-V-compliant iterative divider (div-by-zero, signed overflow).
- Uses a valid/ready handshake so the controller FSM can stall on long operations.
- Sits between the register-file operand latches (SrcA/SrcB) and the ALUOut register.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divider iteration (1 or 2; XLEN divisible by it).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B
- alu_control  in  5  op code (alu_op_e)
- flush  in  1  abort in-flight operation (synchronous)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- alu_result  out  XLEN  result
- zero  out  1  alu_result == 0
- busy  out  1  divider iterating

Behaviour:
- Op codes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL, 0x06 SRL, 0x07 SRA, 0x08 SLT, 0x09 SLTU
  - 0x0A MUL, 0x0B MULH, 0x0C MULHSU, 0x0D MULHU
  - 0x0E DIV, 0x0F DIVU, 0x10 REM, 0x11 REMU
  - Other codes: result 0.
- Shift amount: src_b[$clog2(XLEN)-1:0]. MUL*: full 2*XLEN product; low half for MUL, high half for the others, with signedness per RISC-V.
- Reset values: out_valid=0, alu_result=0, zero=0 (zero register reset to 0, not to 1), busy=0, in_ready=1, FSM=IDLE.
- Handshake:
  - Op accepted when in_valid && in_ready.
  - in_ready=1 only in IDLE.
  - out_valid, alu_result and zero hold stable until out_ready is seen high while out_valid=1.
- FSM states IDLE, DIV_RUN, DIV_FIX, DONE.
  - IDLE, accept non-div op -> DONE. Result registered; out_valid rises the cycle after acceptance (latency 1).
  - IDLE, accept div/rem op:
    - src_b==0 -> DONE, latency 1. Quotient = all ones; remainder = src_a.
    - Signed and src_a==MIN and src_b==-1 -> DONE, latency 1. DIV result = MIN; REM result = 0.
    - Otherwise: latch absolute values and sign flags, load iteration counter -> DIV_RUN, busy=1.
  - DIV_RUN: restoring shift-subtract, DIV_BITS_PER_CYCLE bits per cycle. After XLEN/DIV_BITS_PER_CYCLE cycles -> DIV_FIX.
  - DIV_FIX: apply signs. Quotient negated if the operand signs differ; remainder takes the sign of the dividend. -> DONE, busy=0.
  - Normal divide latency = XLEN/DIV_BITS_PER_CYCLE + 2 cycles from acceptance to out_valid (34 for XLEN=32, radix 1).
  - DONE: out_valid=1. On out_ready -> IDLE, same edge.
- No new op is accepted in the cycle the result is consumed. in_ready rises the following cycle.
- Throughput: 1 op per 2 cycles for single-cycle ops.
- flush, any state: next edge -> IDLE; out_valid=0, busy=0; alu_result unchanged. flush overrides in_valid in the same cycle, so nothing is accepted.
- Operands are sampled only at acceptance; later changes on src_a/src_b/alu_control are ignored.
- Async reset mid-divide: immediately returns all outputs to their reset values.
- zero is computed from the final registered result, including the div-by-zero and overflow cases.

Decomposition:
- Package alu_pkg:
  - alu_op_e (5-bit enum of the op codes above).
  - alu_state_e.
  - Helper function is_div_op().
- Sub-module alu_divider (iterative core, parametrised by XLEN and DIV_BITS_PER_CYCLE):
  - Ports: start, dividend_abs, divisor_abs, done, quotient, remainder.
  - The top module owns the special cases and the sign fix-up.

Test Plan:
- ADD 0x7FFFFFFF+1 (XLEN=32), out_ready=1 -> out_valid one cycle after acceptance; result 0x80000000; zero=0.
- SUB 5-5 with out_ready held 0 for 3 cycles -> result 0 and zero=1 held stable all 3 cycles; in_ready=0 until 1 cycle after consume.
- DIV -7/2 -> result 0xFFFFFFFD at cycle 34; REM -7/2 -> 0xFFFFFFFF; busy high for cycles 1..33.
- DIVU 100/0 -> 0xFFFFFFFF at latency 1; REMU 100/0 -> 100; DIV 0x80000000/-1 -> 0x80000000; REM -> 0 with zero=1.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
- Start DIV 1000/3, assert flush at cycle 10 -> IDLE next edge, out_valid never rises, in_ready=1. Repeat with rst_n low at cycle 10 -> immediate reset values. A following ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, controller states and the
// divide-op classifier used by both the datapath and its users.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLT    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_MUL    = 5'h0A,
    OP_MULH   = 5'h0B,
    OP_MULHSU = 5'h0C,
    OP_MULHU  = 5'h0D,
    OP_DIV    = 5'h0E,
    OP_DIVU   = 5'h0F,
    OP_REM    = 5'h10,
    OP_REMU   = 5'h11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_RUN,
    ST_DIV_FIX,
    ST_DONE
  } alu_state_e;

  // True for every op that goes through the divide path (quotient or remainder).
  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the core controller (master) and the
// multi-cycle ALU (slave).
interface alu_multicycle_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     src_a;
  logic [XLEN-1:0]     src_b;
  logic [ALU_OP_W-1:0] alu_control;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     alu_result;
  logic                zero;
  logic                busy;

  modport master (
    output in_valid, src_a, src_b, alu_control, flush, out_ready,
    input  in_ready, out_valid, alu_result, zero, busy
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_control, flush, out_ready,
    output in_ready, out_valid, alu_result, zero, busy
  );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider on unsigned magnitudes. Retires
// DIV_BITS_PER_CYCLE quotient bits per clock; sign handling lives in the parent.
module alu_divider #(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend_abs,
  input  logic [XLEN-1:0] divisor_abs,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int ITERS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  quo_next;
  logic [XLEN-1:0]  rem_next;
  logic [XLEN:0]    shifted;

  // One cycle of shift-subtract steps; the shifted partial remainder needs one
  // extra bit because it can reach 2*divisor-1.
  always_comb begin
    quo_next = quo;
    rem_next = rem;
    shifted  = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      shifted  = {rem_next, quo_next[XLEN-1]};
      quo_next = {quo_next[XLEN-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
        rem_next    = shifted[XLEN-1:0] - divisor;
        quo_next[0] = 1'b1;
      end else begin
        rem_next = shifted[XLEN-1:0];
      end
    end
  end

  // Iteration counter: loaded on start, counts down to zero once finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(ITERS);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // Working registers: dividend shifts out of quo as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (start) begin
      quo     <= dividend_abs;
      rem     <= '0;
      divisor <= divisor_abs;
    end else if (count != '0) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

  // High during the final iteration; results are settled the following cycle.
  assign done      = (count == CNT_W'(1));
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU between the SrcA/SrcB latches and ALUOut. Single-cycle ops
// and divide corner cases finish in one cycle; regular divides iterate.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  alu_op_e          op;
  alu_state_e       state;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  logic_result;
  logic             mul_a_signed;
  logic             mul_b_signed;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic             signed_div;
  logic             rem_op;
  logic             div_by_zero;
  logic             div_overflow;
  logic             quick;
  logic [XLEN-1:0]  quick_result;
  logic [XLEN-1:0]  dividend_abs;
  logic [XLEN-1:0]  divisor_abs;
  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;
  logic             neg_quotient;
  logic             neg_remainder;
  logic             want_remainder;
  logic [XLEN-1:0]  fixed_result;
  logic [XLEN-1:0]  result_p1;
  logic             zero_p1;
  logic             vld_p1;
  logic             div_busy;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] mag);
    return neg ? (~mag + XLEN'(1)) : mag;
  endfunction

  assign op    = alu_op_e'(bus.alu_control);
  assign shamt = bus.src_b[SHW-1:0];

  // One shared 2*XLEN multiplier; operand extension selects the signedness.
  assign mul_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign mul_b_signed = (op == OP_MULH);
  assign mul_a   = {{XLEN{mul_a_signed & bus.src_a[XLEN-1]}}, bus.src_a};
  assign mul_b   = {{XLEN{mul_b_signed & bus.src_b[XLEN-1]}}, bus.src_b};
  assign product = mul_a * mul_b;

  // Single-cycle ops; unknown codes produce zero.
  always_comb begin
    logic_result = '0;
    case (op)
      OP_ADD:    logic_result = bus.src_a + bus.src_b;
      OP_SUB:    logic_result = bus.src_a - bus.src_b;
      OP_AND:    logic_result = bus.src_a & bus.src_b;
      OP_OR:     logic_result = bus.src_a | bus.src_b;
      OP_XOR:    logic_result = bus.src_a ^ bus.src_b;
      OP_SLL:    logic_result = bus.src_a << shamt;
      OP_SRL:    logic_result = bus.src_a >> shamt;
      OP_SRA:    logic_result = $signed(bus.src_a) >>> shamt;
      OP_SLT:    logic_result = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU:   logic_result = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      OP_MUL:    logic_result = product[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  logic_result = product[2*XLEN-1:XLEN];
      default:   logic_result = '0;
    endcase
  end

  assign signed_div   = (op == OP_DIV) || (op == OP_REM);
  assign rem_op       = (op == OP_REM) || (op == OP_REMU);
  assign div_by_zero  = (bus.src_b == '0);
  assign div_overflow = signed_div && (bus.src_a == MIN_VAL) && (bus.src_b == '1);

  // Results available at acceptance: non-divide ops plus the divide corner cases.
  always_comb begin
    quick        = 1'b1;
    quick_result = '0;
    if (!is_div_op(op)) begin
      quick_result = logic_result;
    end else if (div_by_zero) begin
      quick_result = rem_op ? bus.src_a : '1;
    end else if (div_overflow) begin
      quick_result = rem_op ? '0 : MIN_VAL;
    end else begin
      quick = 1'b0;
    end
  end

  assign dividend_abs = apply_sign(signed_div & bus.src_a[XLEN-1], bus.src_a);
  assign divisor_abs  = apply_sign(signed_div & bus.src_b[XLEN-1], bus.src_b);

  assign accept    = (state == ST_IDLE) && bus.in_valid && !bus.flush;
  assign div_start = accept && !quick;

  alu_divider #(
    .XLEN               (XLEN),
    .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
  ) u_divider (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (div_start),
    .dividend_abs (dividend_abs),
    .divisor_abs  (divisor_abs),
    .done         (div_done),
    .quotient     (div_quotient),
    .remainder    (div_remainder)
  );

  // Sign flags captured with the operands so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (div_start) begin
      neg_quotient   <= signed_div && (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
      neg_remainder  <= signed_div && bus.src_a[XLEN-1];
      want_remainder <= rem_op;
    end
  end

  assign fixed_result = want_remainder ? apply_sign(neg_remainder, div_remainder)
                                       : apply_sign(neg_quotient, div_quotient);

  // Controller FSM with registered result, zero flag, valid and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      vld_p1    <= 1'b0;
      div_busy  <= 1'b0;
    end else if (bus.flush) begin
      state    <= ST_IDLE;
      vld_p1   <= 1'b0;
      div_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (quick) begin
              result_p1 <= quick_result;
              zero_p1   <= (quick_result == '0);
              vld_p1    <= 1'b1;
              state     <= ST_DONE;
            end else begin
              div_busy <= 1'b1;
              state    <= ST_DIV_RUN;
            end
          end
        end
        ST_DIV_RUN: begin
          if (div_done) begin
            state <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          result_p1 <= fixed_result;
          zero_p1   <= (fixed_result == '0);
          vld_p1    <= 1'b1;
          div_busy  <= 1'b0;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == ST_IDLE);
  assign bus.out_valid  = vld_p1;
  assign bus.alu_result = result_p1;
  assign bus.zero       = zero_p1;
  assign bus.busy       = div_busy;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (XLEN=32, radix 1) with a result scoreboard.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_result;

  alu_multicycle_if #(.XLEN(XLEN)) bus ();

  alu_multicycle #(.XLEN(XLEN), .DIV_BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op, let it be accepted on the next edge, then scramble the inputs.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.in_valid    = 1'b1;
    check("in_ready_at_issue", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.src_a       = $urandom();
    bus.src_b       = $urandom();
    bus.alu_control = 5'h1F;
    if (push) exp_q.push_back(exp);
  endtask

  // Called one step after the accepting edge (cycle 1). Checks latency, busy
  // cycles, result and zero; consumes the result if out_ready is high.
  task automatic wait_result(input string tag, input int exp_lat, input int exp_busy);
    int lat = 1;
    int busy_cnt = 0;
    logic [31:0] exp;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_busy_done"}, bus.busy, 1'b0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_result"}, bus.alu_result, exp);
    check({tag, "_zero"}, bus.zero, exp == '0);
    last_result = exp;
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
      check({tag, "_ready_back"}, bus.in_ready, 1'b1);
    end
  endtask

  function automatic logic [31:0] model_div(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'h0E:   return $signed(a) / $signed(b);
      5'h0F:   return a / b;
      5'h10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    bit          seen;

    bus.in_valid    = 1'b0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.alu_control = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b1;
    last_result     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.alu_result, 32'h0);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow wrap
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000);
    wait_result("add", 1, 0);

    // SUB to zero with back-pressure
    bus.out_ready = 1'b0;
    issue(OP_SUB, 32'd5, 32'd5, 1, 32'h0);
    wait_result("sub", 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("sub_hold_valid", bus.out_valid, 1'b1);
      check("sub_hold_result", bus.alu_result, 32'h0);
      check("sub_hold_zero", bus.zero, 1'b1);
      check("sub_hold_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    check("sub_consume_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check("sub_consumed_valid", bus.out_valid, 1'b0);
    check("sub_consumed_in_ready", bus.in_ready, 1'b1);

    // Signed divide / remainder
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD);
    wait_result("div_m7_2", 34, 33);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF);
    wait_result("rem_m7_2", 34, 33);

    // Divide corner cases
    issue(OP_DIVU, 32'd100, 32'd0, 1, 32'hFFFF_FFFF);
    wait_result("divu_by0", 1, 0);
    issue(OP_REMU, 32'd100, 32'd0, 1, 32'd100);
    wait_result("remu_by0", 1, 0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    wait_result("div_ovf", 1, 0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0);
    wait_result("rem_ovf", 1, 0);

    // Multiplies
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    wait_result("mulhsu", 1, 0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);
    wait_result("mulhu", 1, 0);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001);
    wait_result("mul", 1, 0);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000);
    wait_result("mulh", 1, 0);

    // Shifts, compares, unknown code
    issue(OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 1, 32'hF800_0000);
    wait_result("sra", 1, 0);
    issue(OP_SLL, 32'h0000_0003, 32'd31, 1, 32'h8000_0000);
    wait_result("sll", 1, 0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
    wait_result("slt", 1, 0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
    wait_result("sltu", 1, 0);
    issue(5'h15, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0);
    wait_result("unknown_op", 1, 0);

    // Unsigned divide
    issue(OP_DIVU, 32'd1000, 32'd3, 1, 32'd333);
    wait_result("divu_1000_3", 34, 33);
    issue(OP_REMU, 32'd1000, 32'd3, 1, 32'd1);
    wait_result("remu_1000_3", 34, 33);

    // Random divides against the language's own division operators
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom();
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 5000)) : $urandom();
      if (rb == 32'h0) rb = 32'd7;
      if (rb == 32'hFFFF_FFFF) rb = 32'd9;
      rop = 5'(5'h0E + (i % 4));
      issue(rop, ra, rb, 1, model_div(rop, ra, rb));
      wait_result("rand_div", 34, 33);
    end

    // Flush mid-divide
    issue(OP_DIV, 32'd1000, 32'd3, 0, 32'h0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_busy", bus.busy, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    check("flush_result_kept", bus.alu_result, last_result);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", seen, 1'b0);

    // Flush beats a simultaneous request
    bus.alu_control = OP_ADD;
    bus.src_a       = 32'd1;
    bus.src_b       = 32'd1;
    bus.in_valid    = 1'b1;
    bus.flush       = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_req_in_ready", bus.in_ready, 1'b1);
    check("flush_req_valid", bus.out_valid, 1'b0);
    check("flush_req_busy", bus.busy, 1'b0);

    // Asynchronous reset mid-divide
    issue(OP_DIV, 32'd1000, 32'd3, 0, 32'h0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b1);
    check("arst_result", bus.alu_result, 32'h0);
    check("arst_zero", bus.zero, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'd1, 32'd1, 1, 32'd2);
    wait_result("add_after_rst", 1, 0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
